// File: rtl/dmem_responder.sv
// Data-memory target for the core's dmem port: word RAM plus an I/O page
// holding GPIO, a free-running cycle counter and a TX FIFO.
module dmem_responder #(
    parameter int MEM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] addr,
    input  logic [31:0] dmem_write_data,
    output logic [31:0] dmem_read_data,
    output logic [31:0] gpio_out,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] FULL_COUNT = (CW+1)'(FIFO_DEPTH);

    localparam logic [1:0] REG_GPIO   = 2'd0;
    localparam logic [1:0] REG_CYCLE  = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_TXSTAT = 2'd3;

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] ram_idx;
    logic          io_sel;
    logic [1:0]    io_reg;
    logic [31:0]   cycle_count;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr;
    logic [CW:0]   count;
    logic          overflow;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic [7:0]    count_byte;
    logic          unused_addr_bits;

    assign ram_idx = addr[AW+1:2];
    assign io_sel  = addr[31];
    assign io_reg  = addr[3:2];
    assign unused_addr_bits = ^{addr[30:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (dmem_write && !io_sel)
            ram[ram_idx] <= dmem_write_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gpio_out <= '0;
        else if (dmem_write && io_sel && io_reg == REG_GPIO)
            gpio_out <= dmem_write_data;
    end

    // A software write takes priority over the free-running increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_count <= '0;
        else if (dmem_write && io_sel && io_reg == REG_CYCLE)
            cycle_count <= dmem_write_data;
        else
            cycle_count <= cycle_count + 32'd1;
    end

    // TX handshake: a word transfers on a rising edge where tx_valid and
    // tx_ready are both high; tx_data holds the head word until that edge.
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = dmem_write && io_sel && io_reg == REG_TXDATA;
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= dmem_write_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (pop && !push_ok)
                count <= count - 1'b1;
            // Overflow is sticky until software clears it via TXSTAT bit 2.
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (dmem_write && io_sel && io_reg == REG_TXSTAT && dmem_write_data[2])
                overflow <= 1'b0;
        end
    end

    assign count_byte = 8'(count);

    always_comb begin
        dmem_read_data = '0;
        if (!io_sel) begin
            dmem_read_data = ram[ram_idx];
        end else begin
            case (io_reg)
                REG_GPIO:   dmem_read_data = gpio_out;
                REG_CYCLE:  dmem_read_data = cycle_count;
                REG_TXDATA: dmem_read_data = '0;
                REG_TXSTAT: dmem_read_data = {16'b0, count_byte, 5'b0, overflow, empty, full};
                default:    dmem_read_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM, cycle counter,
// TX FIFO fill/overflow/drain, asynchronous reset and GPIO.
module tb_dmem_responder;
    logic        clk;
    logic        reset;
    logic        dmem_write;
    logic [31:0] addr;
    logic [31:0] dmem_write_data;
    logic [31:0] dmem_read_data;
    logic [31:0] gpio_out;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    dmem_responder #(.MEM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_write      (dmem_write),
        .addr            (addr),
        .dmem_write_data (dmem_write_data),
        .dmem_read_data  (dmem_read_data),
        .gpio_out        (gpio_out),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dmem_write = 1'b0;
        addr = a;
        #1;
        check(tag, dmem_read_data, exp);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        dmem_write      = 1'b1;
        addr            = a;
        dmem_write_data = d;
        step();
        dmem_write      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        dmem_write = 1'b0;
        addr = '0;
        dmem_write_data = '0;
        tx_ready = 1'b0;
        #2;
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        read_chk("rst_txstat", 32'h8000_000C, 32'h0000_0002);
        read_chk("rst_cycle", 32'h8000_0004, 32'h0);

        // Counter: release just after an edge, then ten edges.
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        read_chk("cycle_10", 32'h8000_0004, 32'd10);
        write_word(32'h8000_0004, 32'hFFFF_FFFE);
        read_chk("cycle_load", 32'h8000_0004, 32'hFFFF_FFFE);
        step();
        read_chk("cycle_max", 32'h8000_0004, 32'hFFFF_FFFF);
        step();
        read_chk("cycle_wrap", 32'h8000_0004, 32'h0);

        // RAM store/load, alias, and read-during-write returns old data.
        write_word(32'h0000_0010, 32'hDEAD_BEEF);
        read_chk("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
        read_chk("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
        dmem_write = 1'b1;
        addr = 32'h0000_0010;
        dmem_write_data = 32'h1234_5678;
        #1;
        check("ram_rdw_old", dmem_read_data, 32'hDEAD_BEEF);
        step();
        dmem_write = 1'b0;
        read_chk("ram_rdw_new", 32'h0000_0010, 32'h1234_5678);

        // FIFO fill and overflow with tx_ready low.
        for (int i = 1; i <= 4; i++) write_word(32'h8000_0008, 32'(i));
        read_chk("fifo_full_stat", 32'h8000_000C, 32'h0000_0401);
        check("fifo_head1", tx_data, 32'd1);
        write_word(32'h8000_0008, 32'd5);
        read_chk("fifo_ovf_stat", 32'h8000_000C, 32'h0000_0405);
        check("fifo_head_after_drop", tx_data, 32'd1);
        write_word(32'h8000_000C, 32'h4);
        read_chk("fifo_ovf_clear", 32'h8000_000C, 32'h0000_0401);

        // Push into a full FIFO while popping.
        tx_ready = 1'b1;
        write_word(32'h8000_0008, 32'd6);
        tx_ready = 1'b0;
        read_chk("fifo_full_pushpop", 32'h8000_000C, 32'h0000_0401);

        exp_q = '{32'd2, 32'd3, 32'd4, 32'd6};
        tx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check("drain_valid", {31'b0, tx_valid}, 32'h1);
            check("drain_data", tx_data, exp_q.pop_front());
            step();
        end
        check("drain_valid_low", {31'b0, tx_valid}, 32'h0);
        read_chk("drain_empty_stat", 32'h8000_000C, 32'h0000_0002);
        step();
        read_chk("ready_while_empty", 32'h8000_000C, 32'h0000_0002);
        tx_ready = 1'b0;

        // Asynchronous reset mid-cycle with a transfer pending.
        write_word(32'h8000_0008, 32'd7);
        write_word(32'h8000_0008, 32'd8);
        write_word(32'h8000_0008, 32'd9);
        write_word(32'h8000_0000, 32'h55);
        check("pre_rst_gpio", gpio_out, 32'h55);
        read_chk("pre_rst_stat", 32'h8000_000C, 32'h0000_0300);
        tx_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rst_gpio", gpio_out, 32'h0);
        #1;
        reset = 1'b0;
        read_chk("post_rst_stat", 32'h8000_000C, 32'h0000_0002);
        step();
        tx_ready = 1'b0;

        // GPIO, I/O page aliasing and the write-only TXDATA read.
        write_word(32'h8000_0000, 32'h0000_A5A5);
        check("gpio_out", gpio_out, 32'h0000_A5A5);
        read_chk("gpio_read", 32'h8000_0000, 32'h0000_A5A5);
        read_chk("gpio_alias", 32'h8000_0010, 32'h0000_A5A5);
        read_chk("txdata_read", 32'h8000_0008, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's dmem port. It is the target side of the interface on which the core drives dmem_write, alu_out and dmem_write_data, and samples dmem_read_data.
- Contains a word RAM and a small memory-mapped I/O page: a GPIO output register, a free-running cycle counter, and a TX FIFO. The FIFO is drained by an external consumer over a valid/ready handshake.
- Sits at the top level beside the core and instruction memory.

Parameters:
- MEM_WORDS, 64: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_write  in  1  write strobe from the core's MEM stage.
- addr  in  32  byte address (core alu_out); addr[1:0] ignored.
- dmem_write_data  in  32  store data.
- dmem_read_data  out  32  read data; combinational from addr.
- gpio_out  out  32  GPIO output register.
- tx_data  out  32  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head word.

Behaviour:
- Region select: addr[31]=0 selects RAM; addr[31]=1 selects the I/O page.
- RAM indexing: word index = addr[log2(MEM_WORDS)+1:2]. Higher address bits are ignored, so RAM aliases and wraps.
- RAM read: combinational, zero latency. dmem_read_data is valid in the same cycle addr is presented, because the core registers it at the next edge.
- RAM write: when dmem_write=1, the word is written at the rising edge. A read of the same address in the same cycle returns the old value.
- RAM is not cleared by reset.
- I/O map, decoded on addr[3:2] when addr[31]=1 (addr[30:4] ignored):
  - 0x8000_0000 GPIO: R/W; write loads gpio_out.
  - 0x8000_0004 CYCLE: counter increments every cycle and wraps at 2^32-1 to 0. A write loads the written value, and that value is visible on the next cycle. Write wins over increment in the same cycle.
  - 0x8000_0008 TXDATA: write pushes dmem_write_data; read returns 0.
  - 0x8000_000C TXSTAT: read returns {16'b0, count[7:0], 5'b0, overflow, empty, full}. A write with bit2=1 clears overflow; other bits are ignored.
- FIFO:
  - Circular buffer with read pointer, write pointer and count (log2(FIFO_DEPTH)+1 bits); pointers wrap modulo FIFO_DEPTH.
  - tx_valid = (count != 0). tx_data = mem[rd_ptr] whenever tx_valid=1, and is held stable until a pop.
  - Pop: tx_valid & tx_ready at the rising edge.
  - Push: dmem_write to TXDATA.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop: count stays FIFO_DEPTH, data is correct).
  - Push with no room is dropped and sets overflow (sticky).
  - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
  - tx_ready while empty has no effect.
  - The consumer must not depend on tx_data while tx_valid=0.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - gpio_out=0, counter=0, FIFO pointers=0, count=0, overflow=0.
  - tx_valid=0 immediately; any handshake in that cycle is lost.
  - dmem_read_data follows addr combinationally, with register reads returning reset values.
- No stall or wait states toward the core: every access completes in one cycle.

Test Plan:
- RAM store and load: write 0xDEADBEEF at 0x0000_0010. Next cycle, read 0x0000_0010 gives 0xDEADBEEF. Read 0x0000_0110 (alias, MEM_WORDS=64) also gives 0xDEADBEEF.
- Counter: 10 cycles after reset release, CYCLE reads 10. Write 0xFFFF_FFFE, then reads on the next two cycles give 0xFFFF_FFFE and 0xFFFF_FFFF, and the read after that gives 0 (wrap).
- FIFO fill and overflow, tx_ready=0:
  - Push 1,2,3,4: TXSTAT gives count=4, full=1.
  - Push 5: dropped, overflow=1, tx_data still 1.
  - Write TXSTAT with 0x4: overflow=0.
- FIFO drain and concurrency:
  - From full, push 6 while tx_ready=1: pops 1, count stays 4.
  - Drain to empty: consumer sees 2,3,4,6; tx_valid falls after 6; empty=1.
- Reset mid-operation: with 3 entries, gpio_out=0x55 and tx_ready=1, assert reset between clock edges. tx_valid and gpio_out go 0 without waiting for a clock; after release TXSTAT reads 0x0000_0002.
- GPIO and unused addresses: write 0xA5A5 to 0x8000_0000, so gpio_out=0xA5A5. Read 0x8000_0008 gives 0.
